// File: rtl/picoblaze_irq_io_ctrl.sv
// PicoBlaze peripheral: fully decoded I/O registers, a tick timer and a
// prioritised interrupt controller with an IDLE/REQ/HOLD request handshake.
module picoblaze_irq_io_ctrl #(
  parameter int NUM_IRQ  = 4,
  parameter int NUM_OUT  = 2,
  parameter int TICK_DIV = 25000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           port_id,
  input  logic                 write_strobe,
  input  logic                 read_strobe,
  input  logic [7:0]           out_port,
  output logic [7:0]           in_port,
  output logic                 interrupt,
  input  logic                 interrupt_ack,
  input  logic [NUM_IRQ-1:0]   irq_src,
  input  logic [7:0]           gp_in,
  output logic [8*NUM_OUT-1:0] gp_out,
  output logic [NUM_OUT-1:0]   gp_out_wr
);

  localparam int              CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  // Bits that physically exist in PENDING/MASK/EDGE: the sources plus the tick.
  localparam logic [7:0]      IMPL_BITS = 8'((1 << NUM_IRQ) - 1) | 8'h80;

  localparam logic [7:0] ADDR_GP_IN   = 8'h00;
  localparam logic [7:0] ADDR_PENDING = 8'h01;
  localparam logic [7:0] ADDR_MASK    = 8'h02;
  localparam logic [7:0] ADDR_VECTOR  = 8'h03;
  localparam logic [7:0] ADDR_EDGE    = 8'h04;
  localparam logic [7:0] ADDR_CTRL    = 8'h05;
  localparam logic [7:0] ADDR_GP_OUT  = 8'h10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_interrupt;
  logic [NUM_IRQ-1:0]     r_irq_meta;
  logic [NUM_IRQ-1:0]     r_irq_sync;
  logic [NUM_IRQ-1:0]     r_irq_prev;
  logic [7:0]             r_gp_in;
  logic [7:0]             r_pending;
  logic [7:0]             r_mask;
  logic [7:0]             r_edge;
  logic                   r_ctrl_en;
  logic [CNT_W-1:0]       r_tick_cnt;
  logic [8*NUM_OUT-1:0]   r_gp_out;
  logic [NUM_OUT-1:0]     r_gp_out_wr;
  logic [7:0]             r_in_port;

  logic [7:0]             w_set;
  logic [7:0]             w_clr;
  logic [7:0]             w_active;
  logic [2:0]             w_vec_idx;
  logic [7:0]             w_vector;
  logic [7:0]             w_rdata;
  logic                   w_tick_wrap;
  logic                   w_wr_ack;
  logic                   w_unused_ok;

  // Reads have no side effects, so the read qualifier is not needed.
  assign w_unused_ok = &{1'b0, read_strobe};

  assign w_active    = r_pending & r_mask;
  assign w_tick_wrap = r_ctrl_en && (r_tick_cnt == TICK_LAST);
  assign w_clr       = (write_strobe && port_id == ADDR_PENDING) ? out_port : 8'h00;
  assign w_wr_ack    = write_strobe && (port_id == ADDR_PENDING || port_id == ADDR_MASK);

  // NOTE: every combinational output gets a default first so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_set = 8'h00;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_set[i] = r_edge[i] ? (r_irq_sync[i] & ~r_irq_prev[i]) : r_irq_sync[i];
    end
    w_set[7] = w_tick_wrap;
  end

  // Scan downward so the lowest active index is the one left standing.
  always_comb begin
    w_vec_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_active[i]) w_vec_idx = 3'(i);
    end
    w_vector = (|w_active) ? {1'b1, 4'b0000, w_vec_idx} : 8'h00;
  end

  always_comb begin
    w_rdata = 8'h00;
    case (port_id)
      ADDR_GP_IN:   w_rdata = r_gp_in;
      ADDR_PENDING: w_rdata = r_pending;
      ADDR_MASK:    w_rdata = r_mask;
      ADDR_VECTOR:  w_rdata = w_vector;
      ADDR_EDGE:    w_rdata = r_edge;
      ADDR_CTRL:    w_rdata = {7'b0000000, r_ctrl_en};
      default:      w_rdata = 8'h00;
    endcase
    for (int k = 0; k < NUM_OUT; k++) begin
      if (port_id == ADDR_GP_OUT + 8'(k)) w_rdata = r_gp_out[8*k +: 8];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (|w_active) w_state_next = ST_REQ;
      ST_REQ: begin
        if (interrupt_ack)   w_state_next = ST_HOLD;
        else if (~|w_active) w_state_next = ST_IDLE;
      end
      ST_HOLD: if (w_wr_ack) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_interrupt <= 1'b0;
      r_irq_meta  <= '0;
      r_irq_sync  <= '0;
      r_irq_prev  <= '0;
      r_gp_in     <= 8'h00;
      r_pending   <= 8'h00;
      r_mask      <= 8'h00;
      r_edge      <= 8'h00;
      r_ctrl_en   <= 1'b0;
      r_tick_cnt  <= '0;
      r_gp_out    <= '0;
      r_gp_out_wr <= '0;
      r_in_port   <= 8'h00;
    end else begin
      r_state     <= w_state_next;
      r_interrupt <= (w_state_next == ST_REQ);
      r_irq_meta  <= irq_src;
      r_irq_sync  <= r_irq_meta;
      r_irq_prev  <= r_irq_sync;
      r_gp_in     <= gp_in;
      r_in_port   <= w_rdata;
      // Set is OR'd in after the clear so a same-cycle set always survives.
      r_pending   <= ((r_pending & ~w_clr) | w_set) & IMPL_BITS;

      if (r_ctrl_en) r_tick_cnt <= w_tick_wrap ? '0 : r_tick_cnt + 1'b1;
      else           r_tick_cnt <= '0;

      if (write_strobe && port_id == ADDR_MASK) r_mask    <= out_port & IMPL_BITS;
      if (write_strobe && port_id == ADDR_EDGE) r_edge    <= out_port & IMPL_BITS;
      if (write_strobe && port_id == ADDR_CTRL) r_ctrl_en <= out_port[0];

      r_gp_out_wr <= '0;
      for (int k = 0; k < NUM_OUT; k++) begin
        if (write_strobe && port_id == ADDR_GP_OUT + 8'(k)) begin
          r_gp_out[8*k +: 8] <= out_port;
          r_gp_out_wr[k]     <= 1'b1;
        end
      end
    end
  end

  assign in_port   = r_in_port;
  assign interrupt = r_interrupt;
  assign gp_out    = r_gp_out;
  assign gp_out_wr = r_gp_out_wr;

endmodule

// File: tb/tb_picoblaze_irq_io_ctrl.sv
// Directed bench for picoblaze_irq_io_ctrl: decode, edge/level interrupts,
// set-versus-clear collision, tick timer and reset override.
module tb_picoblaze_irq_io_ctrl;

  localparam int NUM_IRQ  = 4;
  localparam int NUM_OUT  = 2;
  localparam int TICK_DIV = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [7:0]           port_id;
  logic                 write_strobe;
  logic                 read_strobe;
  logic [7:0]           out_port;
  logic [7:0]           in_port;
  logic                 interrupt;
  logic                 interrupt_ack;
  logic [NUM_IRQ-1:0]   irq_src;
  logic [7:0]           gp_in;
  logic [8*NUM_OUT-1:0] gp_out;
  logic [NUM_OUT-1:0]   gp_out_wr;

  int n_checks = 0;
  int n_errors = 0;

  picoblaze_irq_io_ctrl #(
    .NUM_IRQ (NUM_IRQ),
    .NUM_OUT (NUM_OUT),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .out_port     (out_port),
    .in_port      (in_port),
    .interrupt    (interrupt),
    .interrupt_ack(interrupt_ack),
    .irq_src      (irq_src),
    .gp_in        (gp_in),
    .gp_out       (gp_out),
    .gp_out_wr    (gp_out_wr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1 ns after.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    port_id      = addr;
    out_port     = data;
    write_strobe = 1'b1;
    step(1);
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    port_id     = addr;
    read_strobe = 1'b1;
    step(1);
    read_strobe = 1'b0;
    check(tag, in_port, exp);
  endtask

  initial begin
    reset         = 1'b1;
    port_id       = 8'h00;
    write_strobe  = 1'b0;
    read_strobe   = 1'b0;
    out_port      = 8'h00;
    interrupt_ack = 1'b0;
    irq_src       = '0;
    gp_in         = 8'h00;
    step(2);
    check("rst_in_port",   in_port,   8'h00);
    check("rst_interrupt", interrupt, 1'b0);
    check("rst_gp_out",    gp_out,    16'h0000);
    check("rst_gp_out_wr", gp_out_wr, 2'b00);
    reset = 1'b0;
    step(1);

    // Decode and output registers
    wr(8'h11, 8'hA5);
    check("wr11_gp_out",    gp_out,    16'hA500);
    check("wr11_pulse",     gp_out_wr, 2'b10);
    step(1);
    check("wr11_pulse_end", gp_out_wr, 2'b00);
    check("rd11",           in_port,   8'hA5);
    rd(8'h3F, 8'h00, "rd_unmapped");
    wr(8'h10, 8'h3C);
    check("wr10_gp_out",    gp_out,    16'hA53C);
    check("wr10_pulse",     gp_out_wr, 2'b01);
    rd(8'h10, 8'h3C, "rd10");
    rd(8'h12, 8'h00, "rd12_unimpl");

    // GP_IN shows the input two edges later
    gp_in = 8'h5A;
    rd(8'h00, 8'h00, "gp_in_lat1");
    rd(8'h00, 8'h5A, "gp_in_lat2");

    // Unimplemented MASK/EDGE bits read back as 0
    wr(8'h02, 8'hFF);
    rd(8'h02, 8'h8F, "mask_impl_bits");
    wr(8'h04, 8'hFF);
    rd(8'h04, 8'h8F, "edge_impl_bits");

    // Edge interrupt on source 2
    wr(8'h04, 8'h04);
    wr(8'h02, 8'h04);
    port_id = 8'h01;
    irq_src = 4'b0100;
    step(2);
    check("edge_no_irq_e1", interrupt, 1'b0);
    step(1);
    check("edge_no_irq_e2", interrupt, 1'b0);
    step(1);
    check("edge_pending",   in_port,   8'h04);
    check("edge_irq",       interrupt, 1'b1);
    rd(8'h03, 8'h82, "edge_vector");

    // Service: ack then write-1-to-clear
    interrupt_ack = 1'b1;
    step(1);
    interrupt_ack = 1'b0;
    check("ack_irq_low", interrupt, 1'b0);
    step(2);
    check("hold_irq_low", interrupt, 1'b0);
    rd(8'h01, 8'h04, "hold_pending");
    wr(8'h01, 8'h04);
    step(1);
    check("clr_pending", in_port,   8'h00);
    check("clr_irq_low", interrupt, 1'b0);
    irq_src = '0;
    step(3);
    check("idle_irq_low", interrupt, 1'b0);

    // Level interrupt on source 1, collision keeps the bit
    wr(8'h02, 8'h00);
    wr(8'h04, 8'h00);
    irq_src = 4'b0010;
    step(3);
    rd(8'h01, 8'h02, "level_pending");
    wr(8'h01, 8'h02);
    step(1);
    check("level_collision", in_port, 8'h02);
    irq_src = '0;
    step(3);
    wr(8'h01, 8'h02);
    step(1);
    check("level_cleared", in_port, 8'h00);

    // Tick timer: wraps every TICK_DIV cycles into PENDING[7]
    wr(8'h02, 8'h80);
    wr(8'h05, 8'h01);
    port_id = 8'h01;
    step(4);
    check("tick_not_yet",   in_port,   8'h00);
    check("tick_irq_low",   interrupt, 1'b0);
    step(1);
    check("tick_pending",   in_port,   8'h80);
    check("tick_irq",       interrupt, 1'b1);
    rd(8'h03, 8'h87, "tick_vector");
    wr(8'h01, 8'h80);
    step(1);
    check("tick_cleared",   in_port,   8'h00);
    check("req_drop_noack", interrupt, 1'b0);
    step(1);
    check("tick_period",    in_port,   8'h80);
    check("tick_irq_again", interrupt, 1'b1);

    // Reset in REQ, with a simultaneous write, overrides everything
    reset        = 1'b1;
    port_id      = 8'h10;
    out_port     = 8'hFF;
    write_strobe = 1'b1;
    step(1);
    write_strobe = 1'b0;
    check("rst_req_irq",     interrupt, 1'b0);
    check("rst_req_in_port", in_port,   8'h00);
    check("rst_req_gp_out",  gp_out,    16'h0000);
    check("rst_req_wr",      gp_out_wr, 2'b00);
    reset = 1'b0;
    rd(8'h02, 8'h00, "rst_mask");
    rd(8'h04, 8'h00, "rst_edge");
    rd(8'h05, 8'h00, "rst_ctrl");
    step(5);
    rd(8'h01, 8'h00, "rst_pending");
    check("rst_irq_stays", interrupt, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
